// File: rtl/sram_wb_master_bridge.sv
// Bridges a simple SRAM-style request port onto a single-beat Wishbone master.
// One transfer in flight at a time; errors and timeouts are reported through sticky flags.
module sram_wb_master_bridge #(
  parameter int unsigned                  MEM_ADDR_BITS    = 10,
  parameter int unsigned                  WB_ADDRESS_WIDTH = 32,
  parameter int unsigned                  WB_DATA_WIDTH    = 32,
  parameter logic [WB_ADDRESS_WIDTH-1:0]  BASE_ADDR        = {WB_ADDRESS_WIDTH{1'b0}},
  parameter int unsigned                  TIMEOUT          = 256
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [MEM_ADDR_BITS-1:0]      sram_addr,
  input  logic                          sram_read_en,
  input  logic                          sram_write_en,
  input  logic [WB_DATA_WIDTH/8-1:0]    sram_byte_en,
  input  logic [WB_DATA_WIDTH-1:0]      sram_write_data,
  output logic [WB_DATA_WIDTH-1:0]      sram_read_data,
  output logic                          sram_read_valid,
  output logic                          sram_busy,
  output logic [WB_ADDRESS_WIDTH-1:0]   wb_adr,
  output logic [WB_DATA_WIDTH-1:0]      wb_dat_w,
  input  logic [WB_DATA_WIDTH-1:0]      wb_dat_r,
  output logic                          wb_cyc,
  output logic                          wb_stb,
  output logic                          wb_we,
  output logic [WB_DATA_WIDTH/8-1:0]    wb_sel,
  input  logic                          wb_ack,
  input  logic                          wb_err,
  output logic                          bus_err,
  input  logic                          bus_err_clr,
  output logic                          overrun
);

  localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;
  localparam int unsigned SHIFT = $clog2(SEL_W);
  localparam int unsigned CNT_W = (TIMEOUT > 32'd2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 32'd0) ? CNT_W'(TIMEOUT - 32'd1) : {CNT_W{1'b0}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUS  = 1'b1;

  logic [0:0]                  state_r;
  logic [CNT_W-1:0]            tcnt_r;
  logic [WB_ADDRESS_WIDTH-1:0] addr_s;
  logic                        start_s;
  logic                        start_we_s;
  logic                        timeout_s;
  logic                        err_term_s;
  logic                        term_s;
  logic                        ovr_set_s;

  assign sram_busy = (state_r == ST_BUS);

  // Request acceptance, termination decode and byte-address mapping.
  always_comb begin
    start_s    = 1'b0;
    start_we_s = 1'b0;
    timeout_s  = 1'b0;
    err_term_s = 1'b0;
    term_s     = 1'b0;
    ovr_set_s  = 1'b0;
    addr_s     = BASE_ADDR + (WB_ADDRESS_WIDTH'(sram_addr) << SHIFT);
    case (state_r)
      ST_IDLE: begin
        // Write has priority; an all-zero byte mask is a no-op write.
        if (sram_write_en) begin
          start_s    = (sram_byte_en != {SEL_W{1'b0}});
          start_we_s = 1'b1;
        end else if (sram_read_en) begin
          start_s    = 1'b1;
          start_we_s = 1'b0;
        end else begin
          start_s    = 1'b0;
          start_we_s = 1'b0;
        end
      end
      ST_BUS: begin
        ovr_set_s  = sram_write_en | sram_read_en;
        timeout_s  = (TIMEOUT != 32'd0) && (tcnt_r == CNT_LAST);
        err_term_s = wb_err | timeout_s;
        term_s     = wb_ack | err_term_s;
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Bus cycle sequencing, read return path and sticky status flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r         <= ST_IDLE;
      tcnt_r          <= {CNT_W{1'b0}};
      wb_cyc          <= 1'b0;
      wb_stb          <= 1'b0;
      wb_we           <= 1'b0;
      wb_adr          <= {WB_ADDRESS_WIDTH{1'b0}};
      wb_dat_w        <= {WB_DATA_WIDTH{1'b0}};
      wb_sel          <= {SEL_W{1'b0}};
      sram_read_data  <= {WB_DATA_WIDTH{1'b0}};
      sram_read_valid <= 1'b0;
      bus_err         <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      sram_read_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r  <= ST_BUS;
            tcnt_r   <= {CNT_W{1'b0}};
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wb_we    <= start_we_s;
            wb_adr   <= addr_s;
            wb_dat_w <= sram_write_data;
            wb_sel   <= start_we_s ? sram_byte_en : {SEL_W{1'b1}};
          end
        end
        ST_BUS: begin
          if (term_s) begin
            state_r <= ST_IDLE;
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            if (!wb_we) begin
              sram_read_valid <= 1'b1;
              sram_read_data  <= err_term_s ? {WB_DATA_WIDTH{1'b0}} : wb_dat_r;
            end
          end else if (TIMEOUT != 32'd0) begin
            tcnt_r <= tcnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          wb_cyc  <= 1'b0;
          wb_stb  <= 1'b0;
        end
      endcase
      // A new error or overrun event outranks a clear in the same cycle.
      bus_err <= err_term_s | (bus_err & ~bus_err_clr);
      overrun <= ovr_set_s  | (overrun & ~bus_err_clr);
    end
  end

endmodule

// File: tb/tb_sram_wb_master_bridge.sv
// Directed bench for sram_wb_master_bridge: bus and read-return scoreboards fed at request time.
module tb_sram_wb_master_bridge;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          TO   = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  sram_addr;
  logic        sram_read_en, sram_write_en;
  logic [3:0]  sram_byte_en;
  logic [31:0] sram_write_data, sram_read_data;
  logic        sram_read_valid, sram_busy;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [3:0]  wb_sel;
  logic        bus_err, bus_err_clr, overrun;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } bus_t;

  bus_t        exp_bus_q[$];
  logic [31:0] exp_rd_q[$];
  bus_t        cur;
  int          n_chk  = 0;
  int          n_pass = 0;

  sram_wb_master_bridge #(
    .MEM_ADDR_BITS(10), .WB_ADDRESS_WIDTH(32), .WB_DATA_WIDTH(32),
    .BASE_ADDR(BASE), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .sram_addr(sram_addr), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_byte_en(sram_byte_en), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .sram_read_valid(sram_read_valid), .sram_busy(sram_busy),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_cyc(wb_cyc),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err),
    .bus_err(bus_err), .bus_err_clr(bus_err_clr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_adr(input logic [9:0] a);
    return BASE + ({22'd0, a} << 2);
  endfunction

  // Drive one request for a single cycle; record what the bus and read port should show.
  task automatic req(input logic wr, input logic rd, input logic [9:0] a, input logic [3:0] be,
                     input logic [31:0] d, input logic [31:0] rd_exp);
    bus_t e;
    sram_addr = a; sram_write_en = wr; sram_read_en = rd;
    sram_byte_en = be; sram_write_data = d;
    e.adr = model_adr(a); e.dat = d;
    if (wr) begin
      e.we = 1'b1; e.sel = be;
      if (be != 4'h0) exp_bus_q.push_back(e);
    end else if (rd) begin
      e.we = 1'b0; e.sel = 4'hF;
      exp_bus_q.push_back(e);
      exp_rd_q.push_back(rd_exp);
    end
    tick();
    sram_write_en = 1'b0; sram_read_en = 1'b0;
  endtask

  task automatic check_start();
    chk("bus_expected", 32'(exp_bus_q.size() != 0), 32'd1);
    if (exp_bus_q.size() != 0) begin
      cur = exp_bus_q.pop_front();
      chk("start_cyc", wb_cyc, 1);
      chk("start_stb", wb_stb, 1);
      chk("start_busy", sram_busy, 1);
      chk("start_adr", wb_adr, cur.adr);
      chk("start_we", wb_we, cur.we);
      chk("start_sel", wb_sel, cur.sel);
      if (cur.we) chk("start_dat_w", wb_dat_w, cur.dat);
    end
  endtask

  task automatic respond(input int waits, input logic ack, input logic err, input logic [31:0] rdata);
    repeat (waits) begin
      tick();
      chk("hold_cyc", wb_cyc, 1);
      chk("hold_adr", wb_adr, cur.adr);
      chk("hold_sel", wb_sel, cur.sel);
      chk("hold_we", wb_we, cur.we);
      chk("hold_rv", sram_read_valid, 0);
    end
    wb_ack = ack; wb_err = err; wb_dat_r = rdata;
    tick();
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = 32'h0;
    chk("term_cyc", wb_cyc, 0);
    chk("term_stb", wb_stb, 0);
    chk("term_busy", sram_busy, 0);
  endtask

  task automatic check_rv();
    if (exp_rd_q.size() != 0) begin
      chk("rv_pulse", sram_read_valid, 1);
      chk("rd_data", sram_read_data, exp_rd_q.pop_front());
      tick();
      chk("rv_single", sram_read_valid, 0);
    end else begin
      chk("rv_none", sram_read_valid, 0);
      tick();
      chk("rv_none_next", sram_read_valid, 0);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_cyc", wb_cyc, 0);      chk("rst_stb", wb_stb, 0);
    chk("rst_we", wb_we, 0);        chk("rst_adr", wb_adr, 0);
    chk("rst_dat_w", wb_dat_w, 0);  chk("rst_sel", wb_sel, 0);
    chk("rst_rdata", sram_read_data, 0);
    chk("rst_rv", sram_read_valid, 0);
    chk("rst_bus_err", bus_err, 0); chk("rst_overrun", overrun, 0);
    chk("rst_busy", sram_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    int n;
    rstn = 1'b0; sram_addr = 10'h0; sram_read_en = 1'b0; sram_write_en = 1'b0;
    sram_byte_en = 4'h0; sram_write_data = 32'h0; wb_dat_r = 32'h0;
    wb_ack = 1'b0; wb_err = 1'b0; bus_err_clr = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    rstn = 1'b1;
    tick();

    // Read with three wait states
    req(1'b0, 1'b1, 10'h004, 4'h0, 32'h0, 32'hDEAD_BEEF);
    check_start();
    respond(3, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check_rv();

    // Partial write at top of SRAM space
    req(1'b1, 1'b0, 10'h3FF, 4'h6, 32'h1122_3344, 32'h0);
    check_start();
    respond(2, 1'b1, 1'b0, 32'h0);
    check_rv();
    chk("wr_bus_err", bus_err, 0);

    // Read that never terminates: timeout after TO bus cycles
    req(1'b0, 1'b1, 10'h012, 4'h0, 32'h0, 32'h0);
    check_start();
    n = 0;
    while (wb_cyc === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_bus_err", bus_err, 1);
    check_rv();
    bus_err_clr = 1'b1;
    tick();
    bus_err_clr = 1'b0;
    chk("clr_bus_err", bus_err, 0);

    // Write ended by ack+err, with a request (and a clear) while busy
    req(1'b1, 1'b0, 10'h020, 4'hF, 32'hCAFE_F00D, 32'h0);
    check_start();
    sram_read_en = 1'b1; bus_err_clr = 1'b1;
    tick();
    sram_read_en = 1'b0; bus_err_clr = 1'b0;
    chk("overrun_set_wins", overrun, 1);
    respond(1, 1'b1, 1'b1, 32'h0);
    chk("ackerr_bus_err", bus_err, 1);
    chk("ackerr_overrun", overrun, 1);
    check_rv();
    repeat (3) tick();
    chk("no_extra_cyc", wb_cyc, 0);
    chk("no_extra_busy", sram_busy, 0);
    bus_err_clr = 1'b1;
    tick();
    bus_err_clr = 1'b0;
    chk("clr2_bus_err", bus_err, 0);
    chk("clr2_overrun", overrun, 0);

    // Write with empty byte mask completes locally
    req(1'b1, 1'b0, 10'h033, 4'h0, 32'h0000_0055, 32'h0);
    chk("be0_cyc", wb_cyc, 0);
    chk("be0_busy", sram_busy, 0);
    tick();
    chk("be0_cyc_next", wb_cyc, 0);

    // Read and write together: write only
    req(1'b1, 1'b1, 10'h005, 4'h3, 32'hAABB_CCDD, 32'h0);
    check_start();
    respond(0, 1'b1, 1'b0, 32'h0);
    check_rv();
    tick();
    chk("rdwr_single_cyc", wb_cyc, 0);

    // Back-to-back reads: next request in the read_valid cycle
    req(1'b0, 1'b1, 10'h001, 4'h0, 32'h0, 32'h0102_0304);
    check_start();
    respond(0, 1'b1, 1'b0, 32'h0102_0304);
    chk("b2b_rv", sram_read_valid, 1);
    chk("b2b_data", sram_read_data, exp_rd_q.pop_front());
    req(1'b0, 1'b1, 10'h002, 4'h0, 32'h0, 32'h0A0B_0C0D);
    check_start();
    chk("b2b_rv_drop", sram_read_valid, 0);
    respond(1, 1'b1, 1'b0, 32'h0A0B_0C0D);
    check_rv();

    // Reset in the middle of a read
    req(1'b0, 1'b1, 10'h007, 4'h0, 32'h0, 32'h0000_0077);
    check_start();
    rstn = 1'b0;
    tick();
    check_reset_vals();
    exp_rd_q.delete();
    rstn = 1'b1;
    tick();
    chk("post_rst_rv", sram_read_valid, 0);
    chk("post_rst_cyc", wb_cyc, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_wb_master_bridge.md
SRAM_WB_MASTER_BRIDGE -- requirements
Module: sram_wb_master_bridge

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_BITS, default 10, meaning SRAM-side word address width.
REQ-002 The block SHALL have parameter WB_ADDRESS_WIDTH, default 32, meaning Wishbone byte address width.
REQ-003 The block SHALL have parameter WB_DATA_WIDTH, default 32, meaning data width for both sides (multiple of 8).
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, meaning Wishbone byte address mapped to SRAM word 0.
REQ-005 The block SHALL have parameter TIMEOUT, default 256, meaning max BUS-state cycles without termination (0 = disabled).
REQ-006 The block SHALL use one clock and a synchronous, active-low reset: clk  input  1  clock; rstn  input  1  synchronous active-low reset.
REQ-007 The block SHALL have these SRAM-client-facing ports:
- sram_addr  input  MEM_ADDR_BITS  word address
- sram_read_en  input  1  read request
- sram_write_en  input  1  write request
- sram_byte_en  input  WB_DATA_WIDTH/8  write byte enables
- sram_write_data  input  WB_DATA_WIDTH  write data
- sram_read_data  output  WB_DATA_WIDTH  last read data, held
- sram_read_valid  output  1  one-cycle read-complete pulse
- sram_busy  output  1  request in progress
REQ-008 The block SHALL have these Wishbone master ports:
- wb_adr  output  WB_ADDRESS_WIDTH  byte address
- wb_dat_w  output  WB_DATA_WIDTH  write data
- wb_dat_r  input  WB_DATA_WIDTH  read data
- wb_cyc  output  1  cycle
- wb_stb  output  1  strobe
- wb_we  output  1  write enable
- wb_sel  output  WB_DATA_WIDTH/8  byte select
- wb_ack  input  1  acknowledge
- wb_err  input  1  error
REQ-009 The block SHALL have these status ports:
- bus_err  output  1  sticky error flag
- bus_err_clr  input  1  clears bus_err
- overrun  output  1  sticky flag: request while busy

Function
REQ-010 The block SHALL implement FSM states IDLE and BUS; sram_busy SHALL equal (state == BUS).
REQ-011 In IDLE, a sampled sram_write_en or sram_read_en SHALL capture address, data, byte enables and direction into registers and move to BUS; if both are asserted, the write SHALL win and the read SHALL be dropped.
REQ-012 A write with sram_byte_en == 0 SHALL complete locally with no bus cycle; the FSM SHALL stay in IDLE.
REQ-013 wb_cyc and wb_stb SHALL be registered, asserted from the cycle after request acceptance, and held with stable wb_adr/wb_dat_w/wb_we/wb_sel until termination.
REQ-014 wb_adr SHALL equal BASE_ADDR + (sram_addr << log2(WB_DATA_WIDTH/8)), truncated to WB_ADDRESS_WIDTH.
REQ-015 wb_sel SHALL equal the captured byte enables for writes and all-ones for reads.
REQ-016 In BUS, a sampled wb_ack or wb_err SHALL terminate: wb_cyc/wb_stb SHALL deassert the next cycle, and the FSM SHALL return to IDLE.
REQ-017 If wb_ack and wb_err are asserted together, the termination SHALL be treated as an error.
REQ-018 On a read terminated by ack, wb_dat_r SHALL be captured into sram_read_data and sram_read_valid SHALL pulse for exactly one cycle, on the cycle after the ack.
REQ-019 On a read terminated by error or timeout, sram_read_data SHALL be set to 0, sram_read_valid SHALL pulse, and bus_err SHALL be set.
REQ-020 A write terminated by error or timeout SHALL set bus_err and SHALL NOT pulse sram_read_valid.
REQ-021 A timeout counter SHALL clear on BUS entry and increment each BUS cycle without termination; when it reaches TIMEOUT-1, the block SHALL terminate as an error. With TIMEOUT=0 there SHALL be no timeout.
REQ-022 A request asserted while in BUS SHALL be ignored and SHALL set overrun.
REQ-023 bus_err_clr SHALL clear both bus_err and overrun, and a set event SHALL win over a simultaneous clear.
REQ-024 A new request SHALL be accepted in the same cycle that sram_read_valid pulses, giving a minimum of 2 cycles between back-to-back requests.

Reset
REQ-025 While rstn is sampled low, the block SHALL force: state=IDLE, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, wb_sel=0, sram_read_data=0, sram_read_valid=0, bus_err=0, overrun=0, and timeout counter=0.
REQ-026 A reset during BUS SHALL drop wb_cyc/wb_stb at that edge, with no sram_read_valid pulse for the aborted access.

Verification
REQ-027 Read: sram_addr=0x004, read_en for 1 cycle, ack with wb_dat_r=0xDEADBEEF after 3 wait cycles -> wb_adr=0x10, wb_sel=0xF, sram_read_valid pulses once, sram_read_data=0xDEADBEEF.
REQ-028 Write: addr=0x3FF, byte_en=0x6, data=0x11223344, BASE_ADDR=0x1000 -> wb_adr=0x1FFC, wb_we=1, wb_sel=0x6, stable until ack, no read_valid.
REQ-029 Timeout with TIMEOUT=8 and no ack on a read -> cyc drops after 8 BUS cycles, read_valid pulses with data 0, bus_err=1; bus_err_clr -> bus_err=0.
REQ-030 Simultaneous ack+err on a write -> bus_err=1; request issued while busy -> overrun=1, no extra bus cycle.
REQ-031 Write with byte_en=0 -> no wb_cyc, sram_busy stays 0; read_en and write_en together -> single write cycle only.
REQ-032 rstn low mid-BUS -> wb_cyc=0 next edge, no read_valid, all outputs at reset values.
